// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, ALU op codes, controller
// state encoding, decoded-instruction bundle and instruction size.
package cpu_pkg;

  // Bytes per instruction; the program counter advances by this amount.
  localparam int unsigned INSTR_BYTES = 2;
  localparam int unsigned ADDR_W      = 8;

  // Opcodes carried in ir[15:12].
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JZ  = 4'h7;
  localparam logic [3:0] OP_JNZ = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // ALU operation select.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  // Controller states, binary encoded.
  typedef enum logic [2:0] {
    ST_FETCH0    = 3'd0,
    ST_FETCH1    = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  // Decoded view of an opcode.
  typedef struct packed {
    logic       is_alu;
    logic       is_ldi;
    logic       is_jmp;
    logic       is_jz;
    logic       is_jnz;
    logic       is_hlt;
    logic       illegal;
    logic [1:0] alu_op;
  } dec_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder for the fetch/execute controller.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  // Classify the opcode; ALU opcodes 2..5 map onto ALU select 0..3.
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    unique case (opcode)
      OP_NOP: ;
      OP_LDI: dec.is_ldi = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.is_alu = 1'b1;
        dec.alu_op = opcode[1:0] - 2'd2;
      end
      OP_JMP: dec.is_jmp = 1'b1;
      OP_JZ:  dec.is_jz  = 1'b1;
      OP_JNZ: dec.is_jnz = 1'b1;
      OP_HLT: dec.is_hlt = 1'b1;
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fetch_exec_ctrl.sv
// Multi-cycle fetch/decode/execute controller for the 8-bit CPU. Fetches a
// two-byte instruction from byte-wide synchronous memory, decodes it, and
// issues exactly one ALU/register/PC strobe set per instruction.
module fetch_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned INSTR_BYTES = cpu_pkg::INSTR_BYTES,
  parameter int unsigned ADDR_W      = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc,
  input  logic [7:0]        mem_rdata,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              pc_en,
  output logic              jump_en,
  output logic [ADDR_W-1:0] next_pc_value,
  output logic [15:0]       ir,
  output logic              alu_en,
  output logic [1:0]        alu_op,
  output logic [3:0]        reg_sel,
  output logic              reg_we,
  output logic              wb_sel,
  output logic [7:0]        imm,
  output logic              halted,
  output logic              illegal_op
);

  // Offset of the final instruction byte; wraps modulo the address space.
  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(INSTR_BYTES - 1);

  state_t state;
  state_t state_nxt;
  logic   take_br;
  logic   br_cond;
  dec_t   dec;

  instr_decoder u_dec (
    .opcode (ir[15:12]),
    .dec    (dec)
  );

  // Fields that follow ir continuously.
  assign next_pc_value = ir[ADDR_W-1:0];
  assign imm           = ir[7:0];
  assign reg_sel       = ir[11:8];
  assign alu_op        = dec.alu_op;
  assign wb_sel        = dec.is_ldi;

  // Branch decision, captured at the end of EXECUTE.
  assign br_cond = dec.is_jmp
                 | (dec.is_jz  &  zero_flag)
                 | (dec.is_jnz & ~zero_flag);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH0;
    else        state <= state_nxt;
  end

  // Instruction register: high byte lands in FETCH1, low byte in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir <= '0;
    end else begin
      if (state == ST_FETCH1) ir[15:8] <= mem_rdata;
      if (state == ST_DECODE) ir[7:0]  <= mem_rdata;
    end
  end

  // Branch-taken flag and sticky halt indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      take_br <= 1'b0;
      halted  <= 1'b0;
    end else begin
      if (state == ST_EXECUTE)   take_br <= br_cond;
      if (state_nxt == ST_HALT)  halted  <= 1'b1;
    end
  end

  // Next-state and Moore strobe outputs.
  always_comb begin
    state_nxt  = state;
    mem_addr   = pc;
    mem_rd     = 1'b0;
    pc_en      = 1'b0;
    jump_en    = 1'b0;
    alu_en     = 1'b0;
    reg_we     = 1'b0;
    illegal_op = 1'b0;
    unique case (state)
      ST_FETCH0: begin
        mem_rd = run;
        if (run) state_nxt = ST_FETCH1;
      end
      ST_FETCH1: begin
        mem_addr  = pc + LAST_OFS;
        mem_rd    = 1'b1;
        state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        state_nxt = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        alu_en     = dec.is_alu;
        illegal_op = dec.illegal;
        state_nxt  = dec.is_hlt ? ST_HALT : ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        reg_we    = dec.is_ldi | dec.is_alu;
        pc_en     = 1'b1;
        jump_en   = take_br;
        state_nxt = ST_FETCH0;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_FETCH0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_exec_ctrl.sv
// Self-checking bench for fetch_exec_ctrl: directed instructions plus a
// random program, checked per instruction against a reference model.
module tb_fetch_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [7:0]  pc;
  logic [7:0]  mem_rdata = '0;
  logic        zero_flag;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic        pc_en;
  logic        jump_en;
  logic [7:0]  next_pc_value;
  logic [15:0] ir;
  logic        alu_en;
  logic [1:0]  alu_op;
  logic [3:0]  reg_sel;
  logic        reg_we;
  logic        wb_sel;
  logic [7:0]  imm;
  logic        halted;
  logic        illegal_op;

  logic [7:0]  mem [256];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  fetch_exec_ctrl #(.INSTR_BYTES(2), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .pc            (pc),
    .mem_rdata     (mem_rdata),
    .zero_flag     (zero_flag),
    .mem_addr      (mem_addr),
    .mem_rd        (mem_rd),
    .pc_en         (pc_en),
    .jump_en       (jump_en),
    .next_pc_value (next_pc_value),
    .ir            (ir),
    .alu_en        (alu_en),
    .alu_op        (alu_op),
    .reg_sel       (reg_sel),
    .reg_we        (reg_we),
    .wb_sel        (wb_sel),
    .imm           (imm),
    .halted        (halted),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  // Byte-wide synchronous instruction memory: data one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({pc_en, jump_en, alu_en, reg_we, illegal_op});
  endfunction

  // Executes the instruction at pc and checks every cycle against the
  // instruction-level model. Entered and left at a negedge in FETCH0.
  task automatic run_instr(input int unsigned stall, input logic zf);
    logic [7:0]  a0;
    logic [7:0]  a1;
    logic [15:0] ins;
    logic [3:0]  op;
    logic [1:0]  aop;
    bit          is_alu, is_ldi, is_hlt, is_ill, take;
    a0     = pc;
    a1     = pc + 8'd1;
    ins    = {mem[a0], mem[a1]};
    op     = ins[15:12];
    is_alu = (op >= 4'd2) && (op <= 4'd5);
    is_ldi = (op == 4'd1);
    is_hlt = (op == 4'd15);
    is_ill = (op >= 4'd9) && (op <= 4'd14);
    aop    = 2'(op - 4'd2);
    take   = (op == 4'd6) || (op == 4'd7 && zf) || (op == 4'd8 && !zf);

    for (int i = 0; i < int'(stall); i++) begin
      run = 1'b0;
      #1;
      check("stall_rd",   32'(mem_rd),   32'(0));
      check("stall_addr", 32'(mem_addr), 32'(a0));
      check("stall_stb",  strobes(),     32'(0));
      @(negedge clk);
    end

    run = 1'b1;
    zero_flag = 1'($urandom);
    #1;
    check("f0_rd",   32'(mem_rd),   32'(1));
    check("f0_addr", 32'(mem_addr), 32'(a0));
    check("f0_stb",  strobes(),     32'(0));
    @(negedge clk);

    run = 1'($urandom);
    #1;
    check("f1_rd",   32'(mem_rd),   32'(1));
    check("f1_addr", 32'(mem_addr), 32'(a1));
    check("f1_stb",  strobes(),     32'(0));
    @(negedge clk);

    zero_flag = zf;
    #1;
    check("dec_rd",  32'(mem_rd), 32'(0));
    check("dec_stb", strobes(),   32'(0));
    @(negedge clk);

    #1;
    check("ex_ir",  32'(ir),     32'(ins));
    check("ex_rd",  32'(mem_rd), 32'(0));
    check("ex_stb", strobes(),   32'({1'b0, 1'b0, is_alu, 1'b0, is_ill}));
    if (is_alu) check("ex_aluop", 32'(alu_op), 32'(aop));
    check("ex_halt", 32'(halted), 32'(0));
    @(negedge clk);

    zero_flag = 1'($urandom);
    if (is_hlt) begin
      for (int i = 0; i < 22; i++) begin
        run = 1'($urandom);
        #1;
        check("hlt_flag", 32'(halted), 32'(1));
        check("hlt_rd",   32'(mem_rd), 32'(0));
        check("hlt_stb",  strobes(),   32'(0));
        @(negedge clk);
      end
    end else begin
      #1;
      check("wb_stb", strobes(), 32'({1'b1, take, 1'b0, is_alu | is_ldi, 1'b0}));
      if (is_alu || is_ldi) begin
        check("wb_sel", 32'(wb_sel),  32'(is_ldi));
        check("wb_reg", 32'(reg_sel), 32'(ins[11:8]));
      end
      if (is_ldi) check("wb_imm", 32'(imm), 32'(ins[7:0]));
      if (take)   check("wb_tgt", 32'(next_pc_value), 32'(ins[7:0]));
      check("wb_halt", 32'(halted), 32'(0));
      pc = take ? ins[7:0] : pc + 8'd2;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] ins;
    logic        zf;
    int unsigned stall;
  } dir_t;

  dir_t dirs [11] = '{
    '{8'h00, 16'h132A, 1'b0, 0},
    '{8'h04, 16'h6060, 1'b0, 0},
    '{8'h10, 16'h7040, 1'b0, 0},
    '{8'h12, 16'h7040, 1'b1, 0},
    '{8'h14, 16'h8040, 1'b0, 0},
    '{8'h16, 16'h8040, 1'b1, 0},
    '{8'h18, 16'h2500, 1'b0, 0},
    '{8'h1A, 16'hB000, 1'b0, 0},
    '{8'hFF, 16'h1344, 1'b0, 0},
    '{8'h20, 16'h5A7F, 1'b1, 0},
    '{8'h22, 16'h0000, 1'b0, 7}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    run       = 1'b1;
    pc        = 8'h00;
    zero_flag = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ir",    32'(ir),       32'(0));
    check("rst_stb",   strobes(),     32'(0));
    check("rst_halt",  32'(halted),   32'(0));
    check("rst_rd",    32'(mem_rd),   32'(1));
    check("rst_addr",  32'(mem_addr), 32'(0));
    run = 1'b0;
    #1;
    check("rst_rd_run0", 32'(mem_rd), 32'(0));
    @(negedge clk);
    run   = 1'b1;
    rst_n = 1'b1;

    // Directed instructions.
    for (int i = 0; i < 11; i++) begin
      pc = dirs[i].addr;
      mem[dirs[i].addr]        = dirs[i].ins[15:8];
      mem[dirs[i].addr + 8'd1] = dirs[i].ins[7:0];
      run_instr(dirs[i].stall, dirs[i].zf);
    end

    // Asynchronous reset in the middle of an ADD's EXECUTE cycle.
    pc = 8'h30;
    mem[8'h30] = 8'h25;
    mem[8'h31] = 8'h00;
    run = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("ar_alu_before", 32'(alu_en), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_stb",  strobes(),     32'(0));
    check("ar_ir",   32'(ir),       32'(0));
    check("ar_rd",   32'(mem_rd),   32'(1));
    check("ar_addr", 32'(mem_addr), 32'(8'h30));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr(0, 1'b0);

    // Random program; HLT excluded so the run continues.
    for (int i = 0; i < 256; i++) mem[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
    pc = 8'($urandom);
    for (int i = 0; i < 120; i++) begin
      run_instr(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, 1'($urandom));
    end

    // Halt, then recover through reset.
    pc = 8'h50;
    mem[8'h50] = 8'hF0;
    mem[8'h51] = 8'h00;
    run_instr(0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("hlt_rst_flag", 32'(halted), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run   = 1'b1;
    pc    = 8'h00;
    mem[8'h00] = 8'h17;
    mem[8'h01] = 8'h99;
    run_instr(0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_exec_ctrl.md
Name: fetch_exec_ctrl

Overview:
- Multi-cycle control FSM for the 8-bit CPU.
- Sequences the two-byte instruction fetch from byte-wide synchronous instruction memory, then latches and decodes the 16-bit instruction.
- Drives the ALU and register-file strobes.
- Sole driver of the program counter's pc_en / jump_en / next_pc_value inputs: exactly one advance or jump per executed instruction.

Parameters:
- INSTR_BYTES, 2, bytes per instruction; fixed, must equal the PC increment.
- ADDR_W, 8, instruction address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  run enable; low stalls the FSM in FETCH0.
- pc  in  8  current program counter value.
- mem_rdata  in  8  instruction memory read data; valid the cycle after mem_rd.
- zero_flag  in  1  datapath Z flag (registered in datapath).
- mem_addr  out  8  instruction memory address.
- mem_rd  out  1  instruction memory read strobe.
- pc_en  out  1  program counter update strobe.
- jump_en  out  1  select next_pc_value instead of pc+2.
- next_pc_value  out  8  jump target (ir[7:0]).
- ir  out  16  instruction register.
- alu_en  out  1  ALU compute strobe.
- alu_op  out  2  00 ADD, 01 SUB, 10 AND, 11 OR.
- reg_sel  out  4  destination/source register (ir[11:8]).
- reg_we  out  1  register write strobe.
- wb_sel  out  1  0 = ALU result, 1 = immediate.
- imm  out  8  ir[7:0].
- halted  out  1  sticky halt indication.
- illegal_op  out  1  one-cycle pulse on undefined opcode.

Behaviour:
- Format: ir[15:12] opcode, ir[11:8] reg, ir[7:0] imm/target. High byte is at address pc, low byte at pc+1.
- Opcodes: 0 NOP, 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 JMP, 7 JZ, 8 JNZ, F HLT. Opcodes 9-E are illegal and execute as NOP with an illegal_op pulse.
- States: FETCH0, FETCH1, DECODE, EXECUTE, WRITEBACK, HALT.
- Async reset: state=FETCH0, ir=0000, take_br=0, halted=0. All strobes (pc_en, jump_en, alu_en, reg_we, illegal_op) = 0. mem_rd = run, mem_addr = pc.
- FETCH0: mem_addr=pc, mem_rd=run. If run, go to FETCH1; else hold.
- FETCH1: ir[15:8]<=mem_rdata; mem_addr=pc+1 (mod 256, so 0xFF wraps to 0x00); mem_rd=1; go to DECODE. run is ignored after FETCH0.
- DECODE: ir[7:0]<=mem_rdata; go to EXECUTE.
- EXECUTE:
  - ADD..OR: alu_en=1, alu_op=opcode-2.
  - JZ: take_br<=zero_flag. JNZ: take_br<=~zero_flag. JMP: take_br<=1. All other opcodes: take_br<=0.
  - Illegal opcode: illegal_op=1.
  - HLT: go to HALT. Otherwise go to WRITEBACK.
- WRITEBACK:
  - reg_we=1 for LDI (wb_sel=1) and ADD..OR (wb_sel=0).
  - pc_en=1; jump_en=take_br; next_pc_value=ir[7:0].
  - Go to FETCH0.
- HALT: halted=1, all strobes 0, mem_rd=0. Held until rst_n asserted; run is ignored.
- Strobe timing: every strobe is a Moore output of the state register plus ir, asserted for exactly one cycle per instruction.
- Latency: 5 clk per non-halting instruction. pc_en is never asserted for HLT.
- next_pc_value, imm, reg_sel track ir continuously; they are meaningful only when strobed.
- Reset mid-instruction: state returns to FETCH0 immediately. No partial pc_en/reg_we is ever issued; the instruction is refetched from the reset PC.
- Flags: zero_flag is sampled only in EXECUTE of JZ/JNZ. The ALU flag update from the previous instruction is stable by then.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - state encoding (one-hot or binary, fixed in the package);
  - ALU op codes;
  - INSTR_BYTES constant, shared with the program counter increment.
- One natural sub-module: instr_decoder. It is combinational, maps ir[15:12] to {is_alu, is_ldi, is_jmp, is_jz, is_jnz, is_hlt, illegal, alu_op}, and is instantiated once in fetch_exec_ctrl.

Test Plan:
- LDI: mem[0]=0x13, mem[1]=0x2A, release reset, run=1 -> mem_addr 0x00 then 0x01; ir=0x132A after DECODE. WRITEBACK: reg_we=1, wb_sel=1, reg_sel=3, imm=0x2A, pc_en=1, jump_en=0. Next FETCH0 on cycle 6.
- JMP/JZ: at pc=0x04, ir=0x6060 -> WRITEBACK pc_en=1, jump_en=1, next_pc_value=0x60. ir=0x7040 with zero_flag=0 -> jump_en=0; with zero_flag=1 -> jump_en=1, target 0x40. JNZ (ir=0x8040) gives the inverse result.
- ADD: ir=0x2500 -> EXECUTE alu_en=1, alu_op=00; WRITEBACK reg_we=1, wb_sel=0, reg_sel=5.
- HLT/illegal: ir=0xF000 -> halted=1, no pc_en, mem_rd=0 for 20+ cycles until rst_n low. ir=0xB000 -> illegal_op high exactly 1 cycle, pc_en=1, jump_en=0.
- Wrap/stall: pc=0xFF -> FETCH1 mem_addr=0x00. run=0 for 7 cycles in FETCH0 -> state held, mem_rd=0, no strobes; resume on run=1.
- Async reset: assert rst_n low mid-EXECUTE of an ADD (no clock edge) -> state=FETCH0, alu_en=0 immediately. No reg_we/pc_en afterwards until refetch.
